// File: rtl/d_74ls138_dec.sv
// 74LS138-style 3-to-8 decoder with active-low outputs, optionally registered
// so chip selects change only on the clock edge.
module d_74ls138_dec #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       G,
  input  logic       G2A,
  input  logic       G2B,
  output logic [7:0] Y
);

  logic [2:0] sel;
  logic       en;
  logic [7:0] dec;

  // A single enable violation is enough to park every output high.
  always_comb begin
    sel = {C, B, A};
    en  = G & ~G2A & ~G2B;
    dec = 8'hFF;
    if (en) begin
      dec = ~(8'b1 << sel);
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [7:0] y_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          y_q <= 8'hFF;
        end else begin
          y_q <= dec;
        end
      end

      assign Y = y_q;
    end else begin : g_comb
      // clk and rst have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign Y = dec;
    end
  endgenerate

endmodule

// File: tb/tb_d_74ls138_dec.sv
// Bench for d_74ls138_dec: a registered instance checked every cycle against a
// queued reference model, and a combinational instance checked directly.
module tb_d_74ls138_dec;

  logic       clk;
  logic       rst;
  logic [2:0] sel;
  logic       g, g2a, g2b;
  logic [7:0] y_r;

  logic [2:0] c_sel;
  logic       c_g, c_g2a, c_g2b;
  logic [7:0] y_c;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  logic [7:0] exp_q[$];

  d_74ls138_dec #(.REG_OUT(1'b1)) dut_reg (
    .clk(clk), .rst(rst),
    .A(sel[0]), .B(sel[1]), .C(sel[2]),
    .G(g), .G2A(g2a), .G2B(g2b),
    .Y(y_r)
  );

  d_74ls138_dec #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst),
    .A(c_sel[0]), .B(c_sel[1]), .C(c_sel[2]),
    .G(c_g), .G2A(c_g2a), .G2B(c_g2b),
    .Y(y_c)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    sel = 3'd6;
    g   = 1'b1;
    g2a = 1'b0;
    g2b = 1'b0;
  end

  // Reference: output i is low only when enabled, not in reset, and selected.
  function automatic logic [7:0] model(input logic r, input logic [2:0] s,
                                       input logic en_hi, input logic en_a,
                                       input logic en_b);
    logic [7:0] m;
    bit on;
    on = (en_hi === 1'b1) && (en_a === 1'b0) && (en_b === 1'b0) && (r === 1'b0);
    for (int i = 0; i < 8; i++) begin
      m[i] = (on && (i == int'(s))) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Scoreboard: what the register must capture at each edge.
  always @(posedge clk) begin
    if (!done) exp_q.push_back(model(rst, sel, g, g2a, g2b));
  end

  always @(negedge clk) begin
    if (!done && exp_q.size() > 0) check("reg_model", y_r, exp_q.pop_front());
  end

  // Driver: change inputs away from the edge, check the literal one edge later.
  task automatic apply(input logic r, input logic [2:0] s, input logic en_hi,
                       input logic en_a, input logic en_b,
                       input logic [7:0] want, input string name);
    @(negedge clk);
    rst = r;
    sel = s;
    g   = en_hi;
    g2a = en_a;
    g2b = en_b;
    @(posedge clk);
    #1;
    check(name, y_r, want);
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    c_sel = 3'd0;
    c_g   = 1'b0;
    c_g2a = 1'b0;
    c_g2b = 1'b0;

    // Reset dominates, even with a valid enable and select.
    apply(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'hFF, "reset_any");
    apply(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'hFF, "reset_hold_a");
    apply(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'hFF, "reset_hold_b");

    // First edge after release decodes the sampled inputs.
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 3'(i), 1'b1, 1'b0, 1'b0, sweep_exp[i], $sformatf("sweep_sel%0d", i));
    end

    apply(1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 8'hFF, "g_low");
    apply(1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 8'hFF, "g2a_high");
    apply(1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 8'hFF, "g2b_high");
    apply(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 8'h7F, "reenable_sel7");

    // Every disabling enable combination across every select.
    for (int e = 0; e < 8; e++) begin
      if (e == 3'b100) continue;
      for (int s = 0; s < 8; s++) begin
        apply(1'b0, 3'(s), e[2], e[1], e[0], 8'hFF, $sformatf("disable_e%0d_s%0d", e, s));
      end
    end

    // Reset pulse in the middle of an active decode.
    apply(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'hDF, "pre_pulse_sel5");
    apply(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'hFF, "mid_reset");
    apply(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'hDF, "post_reset_sel5");

    // Combinational build: output follows inputs with no edge.
    @(negedge clk);
    done  = 1'b1;
    c_sel = 3'd2;
    c_g   = 1'b1;
    c_g2a = 1'b0;
    c_g2b = 1'b0;
    #1;
    check("comb_sel2", y_c, 8'hFB);

    for (int v = 0; v < 64; v++) begin
      {c_sel, c_g, c_g2a, c_g2b} = 6'(v);
      #1;
      check($sformatf("comb_vec%0d", v), y_c, model(1'b0, c_sel, c_g, c_g2a, c_g2b));
    end

    // Comb build ignores rst.
    rst   = 1'b1;
    c_sel = 3'd4;
    c_g   = 1'b1;
    c_g2a = 1'b0;
    c_g2b = 1'b0;
    #1;
    check("comb_rst_ignored", y_c, 8'hEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
